// File: rtl/vmem_pkg.sv
// Shared types for the 256-bit vector memory responder.
package vmem_pkg;
  localparam int LINE_BYTES = 32;
  localparam int WORDS_PER_LINE = 8;

  typedef logic [255:0] line_t;
  typedef logic [31:0] byteen_t;

  typedef enum logic {
    IDLE,
    HREAD
  } host_state_t;
endpackage

// File: rtl/vmem_bank_array.sv
// Line storage with byte-lane writes, a registered read port
// and a word peek port for the host path.
module vmem_bank_array
  import vmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  byteen_t       wr_be,
  input  line_t         wr_data,
  input  logic          rd_en,
  input  logic          rd_zero,
  input  logic [AW-1:0] rd_addr,
  output line_t         rd_data,
  input  logic [AW-1:0] peek_addr,
  output line_t         peek_data
);

  line_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Non-blocking update gives old data on a same-edge collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : mem[rd_addr];
    end
  end

  assign peek_data = mem[peek_addr];

endmodule

// File: rtl/vector_mem_responder.sv
// Vector RAM responder: processor line port with priority,
// plus a 32-bit host port for preload and debug.
module vector_mem_responder
  import vmem_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DEPTH = 1024,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_RAM,
  input  logic [LINE_W/8-1:0] byteena_RAM,
  input  logic              rden_RAM,
  input  logic              wren_RAM,
  input  logic [LINE_W-1:0] writeData_RAM,
  output logic [LINE_W-1:0] readData_RAM,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W+2:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [31:0]       host_rdata,
  output logic              oob_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  host_state_t state;

  logic [ADDR_W-1:0] h_line;
  logic [2:0]        h_lane;
  logic              p_req;
  logic              p_ok;
  logic              h_ok;
  logic              h_wr;

  logic [AW-1:0] cap_idx;
  logic [2:0]    cap_lane;
  logic          cap_oob;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  byteen_t       wr_be;
  line_t         wr_data;
  line_t         peek_data;

  assign h_line = host_addr[ADDR_W+2:3];
  assign h_lane = host_addr[2:0];
  assign p_req  = rden_RAM | wren_RAM;
  assign p_ok   = {1'b0, address_RAM} < DEPTH_L;
  assign h_ok   = {1'b0, h_line} < DEPTH_L;

  assign host_ack = reset & (state == IDLE)
                  & host_req & ~p_req;
  assign h_wr = host_ack & host_we;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = address_RAM[AW-1:0];
    wr_be   = byteena_RAM;
    wr_data = writeData_RAM;
    if (wren_RAM) begin
      wr_en = p_ok;
    end else if (h_wr) begin
      wr_en   = h_ok;
      wr_addr = h_line[AW-1:0];
      wr_be   = byteen_t'(32'hF) << {h_lane, 2'b00};
      wr_data = {WORDS_PER_LINE{host_wdata}};
    end
  end

  vmem_bank_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .rd_en    (rden_RAM),
    .rd_zero  (~p_ok),
    .rd_addr  (address_RAM[AW-1:0]),
    .rd_data  (readData_RAM),
    .peek_addr(cap_idx),
    .peek_data(peek_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      cap_idx     <= '0;
      cap_lane    <= '0;
      cap_oob     <= 1'b0;
    end else begin
      host_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (host_ack && !host_we) begin
            state    <= HREAD;
            cap_idx  <= h_line[AW-1:0];
            cap_lane <= h_lane;
            cap_oob  <= ~h_ok;
          end
        end
        HREAD: begin
          host_rvalid <= 1'b1;
          host_rdata  <= cap_oob ? '0
                       : peek_data[32*cap_lane +: 32];
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oob_err <= 1'b0;
    end else if ((p_req && !p_ok) || (host_ack && !h_ok)) begin
      oob_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_mem_responder.sv
// Directed bench for vector_mem_responder.
module tb_vector_mem_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic [13:0]  address_RAM;
  logic [31:0]  byteena_RAM;
  logic         rden_RAM;
  logic         wren_RAM;
  logic [255:0] writeData_RAM;
  logic [255:0] readData_RAM;
  logic         host_req;
  logic         host_we;
  logic [16:0]  host_addr;
  logic [31:0]  host_wdata;
  logic         host_ack;
  logic         host_rvalid;
  logic [31:0]  host_rdata;
  logic         oob_err;

  int compared = 0;
  int mismatched = 0;

  localparam logic [255:0] L_AA = {32{8'hAA}};
  localparam logic [255:0] L_55 = {32{8'h55}};
  localparam logic [255:0] L5 = {{28{8'hAA}}, {4{8'h55}}};
  localparam logic [255:0] L_11 = {32{8'h11}};
  localparam logic [255:0] L_22 = {32{8'h22}};
  localparam logic [255:0] L_33 = {32{8'h33}};
  localparam logic [255:0] L_FF = {32{8'hFF}};

  vector_mem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .address_RAM  (address_RAM),
    .byteena_RAM  (byteena_RAM),
    .rden_RAM     (rden_RAM),
    .wren_RAM     (wren_RAM),
    .writeData_RAM(writeData_RAM),
    .readData_RAM (readData_RAM),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ack     (host_ack),
    .host_rvalid  (host_rvalid),
    .host_rdata   (host_rdata),
    .oob_err      (oob_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pwrite(input logic [13:0] a,
                        input logic [255:0] d,
                        input logic [31:0] be);
    wren_RAM = 1'b1;
    rden_RAM = 1'b0;
    address_RAM = a;
    writeData_RAM = d;
    byteena_RAM = be;
    step();
    wren_RAM = 1'b0;
  endtask

  task automatic pread(input logic [13:0] a);
    rden_RAM = 1'b1;
    wren_RAM = 1'b0;
    address_RAM = a;
    step();
    rden_RAM = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    address_RAM = '0;
    byteena_RAM = '0;
    rden_RAM = 1'b0;
    wren_RAM = 1'b0;
    writeData_RAM = '0;
    host_req = 1'b0;
    host_we = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    step();
    chk("rst_rdata", readData_RAM, '0);
    chk("rst_hrdata", host_rdata, '0);
    chk("rst_ack", host_ack, 1'b0);
    chk("rst_rvalid", host_rvalid, 1'b0);
    chk("rst_oob", oob_err, 1'b0);
    reset = 1'b1;
    step();

    // byte-masked write
    pwrite(14'd5, L_AA, 32'hFFFF_FFFF);
    pwrite(14'd5, L_55, 32'h0000_000F);
    pread(14'd5);
    chk("bytemask", readData_RAM, L5);
    pwrite(14'd5, '0, 32'h0);
    pread(14'd5);
    chk("be_zero", readData_RAM, L5);

    // read/write collision
    pwrite(14'd7, L_11, 32'hFFFF_FFFF);
    rden_RAM = 1'b1;
    wren_RAM = 1'b1;
    address_RAM = 14'd7;
    writeData_RAM = L_22;
    byteena_RAM = 32'hFFFF_FFFF;
    step();
    chk("collide_old", readData_RAM, L_11);
    pread(14'd7);
    chk("collide_new", readData_RAM, L_22);

    // host write stalled behind processor reads
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = {14'd3, 3'd2};
    host_wdata = 32'hDEAD_BEEF;
    rden_RAM = 1'b1;
    address_RAM = 14'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_ack%0d", i), host_ack, 1'b0);
      step();
    end
    rden_RAM = 1'b0;
    #1;
    chk("free_ack", host_ack, 1'b1);
    step();
    host_req = 1'b0;
    pread(14'd3);
    chk("hwr_word", readData_RAM[95:64], 32'hDEAD_BEEF);

    // host read latency, with a processor read in HREAD
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = {14'd3, 3'd2};
    #1;
    chk("hrd_ack_a", host_ack, 1'b1);
    step();
    rden_RAM = 1'b1;
    address_RAM = 14'd5;
    #1;
    chk("hrd_noack", host_ack, 1'b0);
    chk("hrd_rv_a1", host_rvalid, 1'b0);
    step();
    host_req = 1'b0;
    rden_RAM = 1'b0;
    chk("hrd_rvalid", host_rvalid, 1'b1);
    chk("hrd_data", host_rdata, 32'hDEAD_BEEF);
    chk("hrd_proc", readData_RAM, L5);
    step();
    chk("hrd_rv_end", host_rvalid, 1'b0);
    chk("hrd_hold", host_rdata, 32'hDEAD_BEEF);

    // out of range
    pwrite(14'd0, L_33, 32'hFFFF_FFFF);
    chk("oob_pre", oob_err, 1'b0);
    pwrite(14'd1024, L_FF, 32'hFFFF_FFFF);
    chk("oob_set", oob_err, 1'b1);
    pread(14'd1024);
    chk("oob_rd", readData_RAM, '0);
    pread(14'd0);
    chk("oob_line0", readData_RAM, L_33);
    chk("oob_sticky", oob_err, 1'b1);

    // reset during HREAD
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = {14'd3, 3'd2};
    #1;
    chk("rr_ack", host_ack, 1'b1);
    step();
    host_req = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("rr_rdata", readData_RAM, '0);
    chk("rr_hrdata", host_rdata, '0);
    chk("rr_ack0", host_ack, 1'b0);
    chk("rr_rvalid", host_rvalid, 1'b0);
    chk("rr_oob", oob_err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rr_rv%0d", i), host_rvalid, 1'b0);
    end
    reset = 1'b1;
    step();
    chk("rr_rv_post", host_rvalid, 1'b0);
    pread(14'd3);
    chk("rr_keep3", readData_RAM[95:64], 32'hDEAD_BEEF);
    pread(14'd0);
    chk("rr_keep0", readData_RAM, L_33);

    // host read after reset, word 0 of line 5
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = {14'd5, 3'd0};
    #1;
    chk("h5_ack", host_ack, 1'b1);
    step();
    host_req = 1'b0;
    step();
    chk("h5_rvalid", host_rvalid, 1'b1);
    chk("h5_data", host_rdata, 32'h5555_5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
